// File: rtl/display_scan_scheduler_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan scheduler.
package display_scan_scheduler_pkg;

  // Digit codes understood by the downstream BCD-to-7-segment converter.
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_F     = 4'hA;
  localparam logic [3:0] CODE_C     = 4'hB;

  // Active-low one-hot digit enables.
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;

  typedef enum logic [0:0] {
    StGuard,
    StOn
  } state_e;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    unique case (idx)
      2'd0:    an = AN_D0;
      2'd1:    an = AN_D1;
      2'd2:    an = AN_D2;
      default: an = AN_D3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/display_scan_scheduler_refresh_timer.sv
// Phase timer: counts cycles spent in the current phase and flags the last one.
// The counter restarts from zero after the terminal cycle, so each phase length
// is simply selected by last_i (= length - 1) while the phase is active.
module display_scan_scheduler_refresh_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [Width-1:0] last_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == last_i);

  // Next count: wrap on terminal cycle or when held in clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tc_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Each digit gets a GUARD phase (all off) followed by an ON phase. The shown
// measurement is snapshotted at the start of digit 0 so a frame is consistent.
module display_scan_scheduler
  import display_scan_scheduler_pkg::*;
#(
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       display_en,
  input  logic       funct_select,
  input  logic [2:0] cuenta_frec,
  input  logic [3:0] cuenta_CT,
  output logic [3:0] c_digit,
  output logic [3:0] c_anodo,
  output logic       frame_done
);

  localparam int unsigned MaxLen = (PRESCALE > GUARD_CYC) ? PRESCALE : GUARD_CYC;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYC - 1);
  localparam logic [CntW-1:0] OnLast    = CntW'(PRESCALE - 1);

  state_e     state_q;
  logic [1:0] idx_q;
  logic       snap_mode_q;
  logic [3:0] snap_val_q;
  logic [3:0] digit_q;
  logic [3:0] anodo_q;
  logic       frame_done_q;

  logic            tc;
  logic [CntW-1:0] phase_last;
  logic            take_snap;
  logic [3:0]      live_val;
  logic            cur_mode;
  logic [3:0]      cur_val;
  logic [3:0]      next_digit;

  assign phase_last = (state_q == StGuard) ? GuardLast : OnLast;

  display_scan_scheduler_refresh_timer #(
    .Width(CntW)
  ) u_refresh_timer (
    .clk_i  (clock),
    .rst_ni (reset),
    .clear_i(!display_en),
    .last_i (phase_last),
    .tc_o   (tc)
  );

  // Pick the live inputs on the snapshot edge, otherwise the frozen snapshot,
  // then split into the code for the digit about to light.
  always_comb begin
    take_snap = (state_q == StGuard) && (idx_q == 2'd0);
    live_val  = funct_select ? cuenta_CT : {1'b0, cuenta_frec};
    cur_mode  = take_snap ? funct_select : snap_mode_q;
    cur_val   = take_snap ? live_val : snap_val_q;
    unique case (idx_q)
      2'd0:    next_digit = (cur_val >= 4'd10) ? (cur_val - 4'd10) : cur_val;
      2'd1:    next_digit = (cur_val >= 4'd10) ? 4'd1 : CODE_BLANK;
      2'd2:    next_digit = CODE_BLANK;
      default: next_digit = cur_mode ? CODE_C : CODE_F;
    endcase
  end

  // Scan FSM with registered outputs; disable forces a clean restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StGuard;
      idx_q        <= 2'd0;
      snap_mode_q  <= 1'b0;
      snap_val_q   <= 4'd0;
      digit_q      <= CODE_BLANK;
      anodo_q      <= AN_OFF;
      frame_done_q <= 1'b0;
    end else if (!display_en) begin
      state_q      <= StGuard;
      idx_q        <= 2'd0;
      digit_q      <= CODE_BLANK;
      anodo_q      <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (tc) begin
        if (state_q == StGuard) begin
          state_q <= StOn;
          anodo_q <= anode_for(idx_q);
          digit_q <= next_digit;
          if (take_snap) begin
            snap_mode_q <= funct_select;
            snap_val_q  <= live_val;
          end
        end else begin
          state_q      <= StGuard;
          anodo_q      <= AN_OFF;
          digit_q      <= CODE_BLANK;
          idx_q        <= idx_q + 2'd1;
          frame_done_q <= (idx_q == 2'd3);
        end
      end
    end
  end

  assign c_digit    = digit_q;
  assign c_anodo    = anodo_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench: a frame-position reference model pushes the expected
// per-cycle outputs; a monitor pops and compares them one cycle at a time.
module tb_display_scan_scheduler;

  localparam int P     = 4;
  localparam int G     = 1;
  localparam int SLOT  = G + P;
  localparam int FRAME = 4 * SLOT;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       display_en = 1'b1;
  logic       funct_select = 1'b0;
  logic [2:0] cuenta_frec = 3'd0;
  logic [3:0] cuenta_CT = 4'd0;
  logic [3:0] c_digit;
  logic [3:0] c_anodo;
  logic       frame_done;

  display_scan_scheduler #(
    .PRESCALE (P),
    .GUARD_CYC(G)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .display_en  (display_en),
    .funct_select(funct_select),
    .cuenta_frec (cuenta_frec),
    .cuenta_CT   (cuenta_CT),
    .c_digit     (c_digit),
    .c_anodo     (c_anodo),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;
  bit   snap_mode = 1'b0;
  int   snap_val = 0;

  // Expected outputs at a given position within the frame.
  function automatic exp_t expect_at(int p, bit m, int v, bit fd);
    exp_t e;
    int slot, off;
    slot  = p / SLOT;
    off   = p % SLOT;
    e.fd  = fd;
    if (off < G) begin
      e.an  = 4'hF;
      e.dig = 4'hF;
    end else begin
      e.an = ~(4'b0001 << slot);
      case (slot)
        0:       e.dig = 4'(v % 10);
        1:       e.dig = (v >= 10) ? 4'd1 : 4'hF;
        2:       e.dig = 4'hF;
        default: e.dig = m ? 4'hB : 4'hA;
      endcase
    end
    return e;
  endfunction

  // Reference model: position counter within the frame.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos = 0;
    end else begin
      bit fd;
      fd = 1'b0;
      if (!display_en) begin
        pos = 0;
      end else begin
        if (pos == FRAME - 1) fd = 1'b1;
        pos = (pos + 1) % FRAME;
        if (pos == G) begin
          snap_mode = funct_select;
          snap_val  = funct_select ? int'(cuenta_CT) : int'(cuenta_frec);
        end
      end
      exp_q.push_back(expect_at(pos, snap_mode, snap_val, fd));
    end
  end

  // Monitor: compare every cycle's outputs just after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({c_anodo, c_digit, frame_done} !== e) begin
          errors++;
          $display("FAIL scan_out at %0t: got an=%b dig=%h fd=%b, want an=%b dig=%h fd=%b",
                   $time, c_anodo, c_digit, frame_done, e.an, e.dig, e.fd);
        end
      end
    end
  end

  task automatic set_in(bit m, int v);
    funct_select = m;
    if (m) cuenta_CT = v[3:0];
    else cuenta_frec = v[2:0];
  endtask

  task automatic check_off(string name);
    checks++;
    if ({c_anodo, c_digit, frame_done} !== 9'b1111_1111_0) begin
      errors++;
      $display("FAIL %s: got an=%b dig=%h fd=%b, want an=1111 dig=f fd=0",
               name, c_anodo, c_digit, frame_done);
    end
  endtask

  initial begin
    int mv[6];
    int vv[6];
    bit found;
    mv = '{0, 1, 1, 1, 1, 0};
    vv = '{5, 13, 7, 0, 10, 3};

    set_in(0, 5);
    repeat (2) @(negedge clock);
    check_off("reset_state");
    reset = 1'b1;

    // Directed frames, one value per frame.
    for (int i = 0; i < 6; i++) begin
      set_in(mv[i][0], vv[i]);
      repeat (FRAME) @(negedge clock);
    end

    // Snapshot stability: change inputs during idx2.
    set_in(1, 9);
    repeat (12) @(negedge clock);
    set_in(0, 2);
    repeat (FRAME + 8) @(negedge clock);

    // Disable during idx1 ON, then re-enable with a fresh value.
    repeat (7) @(negedge clock);
    display_en = 1'b0;
    repeat (3) @(negedge clock);
    set_in(1, 12);
    display_en = 1'b1;
    repeat (FRAME + 5) @(negedge clock);

    // Disable exactly on the cycle the frame pulse would rise.
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (pos == FRAME - 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_frame_end: position %0d never reached", FRAME - 1);
    end
    display_en = 1'b0;
    @(negedge clock);
    display_en = 1'b1;
    repeat (FRAME) @(negedge clock);

    // Asynchronous reset in the middle of idx2 ON.
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (c_anodo == 4'b1011) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_idx2: an=%b never reached 1011", c_anodo);
    end
    #2;
    reset = 1'b0;
    #1;
    check_off("async_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (3 * FRAME) @(negedge clock);

    // Randomized inputs and occasional disable pulses.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        funct_select = 1'($urandom);
        cuenta_frec  = 3'($urandom);
        cuenta_CT    = 4'($urandom);
      end
      display_en = ($urandom_range(0, 59) != 0);
      @(negedge clock);
    end
    display_en = 1'b1;
    repeat (2 * FRAME) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
